// File: rtl/gpioemu_master.sv
// gpioemu_master: runs a multiply job on a memory-mapped peripheral over a strobed bus.
// It writes both operands and a trigger, polls the status word, then reads back the product and the ones count.
module gpioemu_master #(
    parameter int STROBE_CYCLES  = 2,
    parameter int POST_TRIG_WAIT = 8,
    parameter int POLL_LIMIT     = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] arg_a,
    input  logic [23:0] arg_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result_w,
    output logic [23:0] ones_l,
    output logic        valid,
    output logic        timeout,
    output logic [15:0] saddress,
    output logic        srd,
    output logic        swr,
    output logic [31:0] sdata_out,
    input  logic [31:0] sdata_in
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        WR_A    = 4'd1,
        WR_B    = 4'd2,
        WR_TRIG = 4'd3,
        WAIT    = 4'd4,
        POLL    = 4'd5,
        RD_W    = 4'd6,
        RD_L    = 4'd7,
        FINISH  = 4'd8
    } state_t;

    // PH_LEAD is the single bus-idle cycle between accepting start and the first SETUP.
    typedef enum logic [1:0] {
        PH_LEAD   = 2'd0,
        PH_SETUP  = 2'd1,
        PH_STROBE = 2'd2,
        PH_HOLD   = 2'd3
    } phase_t;

    localparam logic [15:0] ADDR_A      = 16'h037F;
    localparam logic [15:0] ADDR_B      = 16'h0388;
    localparam logic [15:0] ADDR_TRIG   = 16'h03A0;
    localparam logic [15:0] ADDR_W      = 16'h0390;
    localparam logic [15:0] ADDR_L      = 16'h0398;
    localparam logic [15:0] STROBE_LAST = 16'(STROBE_CYCLES - 1);
    localparam logic [15:0] WAIT_LAST   = 16'(POST_TRIG_WAIT - 1);
    localparam logic [7:0]  POLL_MAX    = 8'(POLL_LIMIT);

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  poll_q, poll_d, poll_inc;
    logic [23:0] arg_a_q, arg_a_d, arg_b_q, arg_b_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic [31:0] result_w_q, result_w_d;
    logic [23:0] ones_l_q, ones_l_d;
    logic        valid_q, valid_d, timeout_q, timeout_d;
    logic [15:0] saddress_q, saddress_d;
    logic        srd_q, srd_d, swr_q, swr_d;
    logic [31:0] sdata_out_q, sdata_out_d;

    // Next-state logic; bus outputs are decoded from the next state so they line up with it.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        poll_d      = poll_q;
        poll_inc    = (poll_q == 8'hFF) ? poll_q : poll_q + 8'd1;
        arg_a_d     = arg_a_q;
        arg_b_d     = arg_b_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        result_w_d  = result_w_q;
        ones_l_d    = ones_l_q;
        valid_d     = valid_q;
        timeout_d   = timeout_q;
        saddress_d  = 16'h0000;
        sdata_out_d = 32'h0000_0000;
        srd_d       = 1'b0;
        swr_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    arg_a_d   = arg_a;
                    arg_b_d   = arg_b;
                    timeout_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = WR_A;
                    phase_d   = PH_LEAD;
                end else begin
                    busy_d = 1'b0;
                end
            end
            WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = POLL;
                    phase_d = PH_SETUP;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            WR_A, WR_B, WR_TRIG, POLL, RD_W, RD_L: begin
                case (phase_q)
                    PH_LEAD: begin
                        phase_d = PH_SETUP;
                    end
                    PH_SETUP: begin
                        phase_d = PH_STROBE;
                        cnt_d   = 16'd0;
                    end
                    PH_STROBE: begin
                        if (cnt_q == STROBE_LAST) begin
                            phase_d = PH_HOLD;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                    PH_HOLD: begin
                        phase_d = PH_SETUP;
                        cnt_d   = 16'd0;
                        case (state_q)
                            WR_A: state_d = WR_B;
                            WR_B: state_d = WR_TRIG;
                            WR_TRIG: begin
                                poll_d = 8'd0;
                                if (POST_TRIG_WAIT == 0) begin
                                    state_d = POLL;
                                end else begin
                                    state_d = WAIT;
                                end
                            end
                            POLL: begin
                                poll_d = poll_inc;
                                if (sdata_in[1]) begin
                                    valid_d = sdata_in[0];
                                    state_d = RD_W;
                                end else if (poll_inc >= POLL_MAX) begin
                                    timeout_d = 1'b1;
                                    done_d    = 1'b1;
                                    busy_d    = 1'b0;
                                    state_d   = FINISH;
                                end else begin
                                    state_d = POLL;
                                end
                            end
                            RD_W: begin
                                result_w_d = sdata_in;
                                state_d    = RD_L;
                            end
                            RD_L: begin
                                ones_l_d = sdata_in[23:0];
                                done_d   = 1'b1;
                                busy_d   = 1'b0;
                                state_d  = FINISH;
                            end
                            default: state_d = IDLE;
                        endcase
                    end
                    default: phase_d = PH_SETUP;
                endcase
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (phase_d != PH_LEAD) begin
            case (state_d)
                WR_A: begin
                    saddress_d  = ADDR_A;
                    sdata_out_d = {8'h00, arg_a_q};
                    swr_d       = (phase_d == PH_STROBE);
                end
                WR_B: begin
                    saddress_d  = ADDR_B;
                    sdata_out_d = {8'h00, arg_b_q};
                    swr_d       = (phase_d == PH_STROBE);
                end
                WR_TRIG: begin
                    saddress_d = ADDR_TRIG;
                    swr_d      = (phase_d == PH_STROBE);
                end
                POLL: begin
                    saddress_d = ADDR_TRIG;
                    srd_d      = (phase_d == PH_STROBE);
                end
                RD_W: begin
                    saddress_d = ADDR_W;
                    srd_d      = (phase_d == PH_STROBE);
                end
                RD_L: begin
                    saddress_d = ADDR_L;
                    srd_d      = (phase_d == PH_STROBE);
                end
                default: saddress_d = 16'h0000;
            endcase
        end else begin
            saddress_d = 16'h0000;
        end
    end

    // State and output registers; reset drops the bus at once and aborts any job.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            phase_q     <= PH_LEAD;
            cnt_q       <= 16'd0;
            poll_q      <= 8'd0;
            arg_a_q     <= 24'd0;
            arg_b_q     <= 24'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_w_q  <= 32'd0;
            ones_l_q    <= 24'd0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            saddress_q  <= 16'd0;
            srd_q       <= 1'b0;
            swr_q       <= 1'b0;
            sdata_out_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            poll_q      <= poll_d;
            arg_a_q     <= arg_a_d;
            arg_b_q     <= arg_b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_w_q  <= result_w_d;
            ones_l_q    <= ones_l_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
            saddress_q  <= saddress_d;
            srd_q       <= srd_d;
            swr_q       <= swr_d;
            sdata_out_q <= sdata_out_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result_w  = result_w_q;
    assign ones_l    = ones_l_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;
    assign saddress  = saddress_q;
    assign srd       = srd_q;
    assign swr       = swr_q;
    assign sdata_out = sdata_out_q;

endmodule

// File: tb/tb_gpioemu_master.sv
// Scoreboard bench for gpioemu_master: a scripted peripheral answers the bus, and a monitor checks bus
// transactions and job results against expectations queued by the stimulus.
module tb_gpioemu_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] arg_a, arg_b;
    logic        busy, done, valid, timeout, srd, swr;
    logic [31:0] result_w, sdata_out, sdata_in;
    logic [23:0] ones_l;
    logic [15:0] saddress;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        is_wr;
        logic [15:0] addr;
        logic [31:0] data;
    } bus_ev_t;

    typedef struct {
        logic [31:0] result_w;
        logic [23:0] ones_l;
        logic        valid;
        logic        timeout;
        int          polls;
    } job_exp_t;

    bus_ev_t  bus_q[$];
    job_exp_t job_q[$];

    // Scripted peripheral: status goes ready on read number ready_at (0 = never).
    int          ready_at = 0;
    logic        rsp_fit  = 1'b0;
    logic [31:0] rsp_w    = 32'h0;
    logic [31:0] rsp_l    = 32'h0;
    int          rd_cnt;
    logic        rsp_srd_prev;

    gpioemu_master dut (
        .clk(clk), .reset(reset), .start(start), .arg_a(arg_a), .arg_b(arg_b),
        .busy(busy), .done(done), .result_w(result_w), .ones_l(ones_l), .valid(valid),
        .timeout(timeout), .saddress(saddress), .srd(srd), .swr(swr),
        .sdata_out(sdata_out), .sdata_in(sdata_in)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (saddress)
            16'h03A0: sdata_in = (ready_at != 0 && rd_cnt >= ready_at) ? {30'h0, 1'b1, rsp_fit} : 32'h0;
            16'h0390: sdata_in = rsp_w;
            16'h0398: sdata_in = rsp_l;
            default:  sdata_in = 32'hDEAD_BEEF;
        endcase
    end

    always @(posedge clk) begin
        if (reset) begin
            rd_cnt <= 0;
        end else if (swr && saddress == 16'h03A0) begin
            rd_cnt <= 0;
        end else if (srd && !rsp_srd_prev && saddress == 16'h03A0) begin
            rd_cnt <= rd_cnt + 1;
        end
        rsp_srd_prev <= srd;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input logic is_wr, input logic [15:0] addr, input logic [31:0] data);
        bus_ev_t ev;
        ev.is_wr = is_wr;
        ev.addr  = addr;
        ev.data  = data;
        bus_q.push_back(ev);
    endtask

    task automatic expect_job(input logic [23:0] a, input logic [23:0] b, input logic rdy,
                              input logic [31:0] w, input logic [23:0] l, input logic v,
                              input logic to, input int polls);
        job_exp_t j;
        push_ev(1'b1, 16'h037F, {8'h00, a});
        push_ev(1'b1, 16'h0388, {8'h00, b});
        push_ev(1'b1, 16'h03A0, 32'h0);
        if (rdy) begin
            push_ev(1'b0, 16'h0390, 32'h0);
            push_ev(1'b0, 16'h0398, 32'h0);
        end
        j.result_w = w;
        j.ones_l   = l;
        j.valid    = v;
        j.timeout  = to;
        j.polls    = polls;
        job_q.push_back(j);
    endtask

    task automatic pulse_start(input logic [23:0] a, input logic [23:0] b);
        @(negedge clk);
        arg_a = a;
        arg_b = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        logic seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk(name, 64'(seen), 64'd1);
    endtask

    // Monitor: compares every bus transaction and every done pulse with the queued expectations.
    initial begin
        logic     swr_prev = 1'b0;
        logic     srd_prev = 1'b0;
        int       polls_seen = 0;
        bus_ev_t  ev;
        job_exp_t j;
        forever begin
            @(negedge clk);
            chk("strobe_excl", 64'(srd && swr), 64'd0);
            if (!busy) chk("idle_bus", {29'h0, saddress, sdata_out, srd, swr}, 64'd0);
            if (reset) begin
                polls_seen = 0;
            end else begin
                if (swr && !swr_prev) begin
                    if (bus_q.size() == 0) begin
                        chk("unexpected_write", 64'(saddress), 64'hFFFF_FFFF);
                    end else begin
                        ev = bus_q.pop_front();
                        chk("wr_kind", 64'(ev.is_wr), 64'd1);
                        chk("wr_addr", 64'(saddress), 64'(ev.addr));
                        chk("wr_data", 64'(sdata_out), 64'(ev.data));
                    end
                end
                if (srd && !srd_prev) begin
                    if (saddress == 16'h03A0) begin
                        polls_seen++;
                    end else if (bus_q.size() == 0) begin
                        chk("unexpected_read", 64'(saddress), 64'hFFFF_FFFF);
                    end else begin
                        ev = bus_q.pop_front();
                        chk("rd_kind", 64'(ev.is_wr), 64'd0);
                        chk("rd_addr", 64'(saddress), 64'(ev.addr));
                    end
                end
                if (done) begin
                    if (job_q.size() == 0) begin
                        chk("unexpected_done", 64'(done), 64'd0);
                    end else begin
                        j = job_q.pop_front();
                        chk("result_w", 64'(result_w), 64'(j.result_w));
                        chk("ones_l", 64'(ones_l), 64'(j.ones_l));
                        chk("valid", 64'(valid), 64'(j.valid));
                        chk("timeout", 64'(timeout), 64'(j.timeout));
                        chk("busy_at_done", 64'(busy), 64'd0);
                        chk("poll_count", 64'(polls_seen), 64'(j.polls));
                    end
                    polls_seen = 0;
                end
            end
            swr_prev = swr;
            srd_prev = srd;
        end
    end

    initial begin
        logic found;
        reset = 1'b1;
        start = 1'b0;
        arg_a = 24'h0;
        arg_b = 24'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_results", {8'h0, result_w, ones_l}, 64'd0);
        chk("rst_flags", 64'({valid, timeout}), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Job 1: 3 x 5, with cycle-exact bus timing from the accepting edge.
        ready_at = 2; rsp_fit = 1'b1; rsp_w = 32'h0000_000F; rsp_l = 32'd2;
        expect_job(24'd3, 24'd5, 1'b1, 32'h0000_000F, 24'd2, 1'b1, 1'b0, 2);
        @(negedge clk);
        arg_a = 24'd3; arg_b = 24'd5; start = 1'b1;
        @(posedge clk); #1;
        chk("t0_busy", 64'(busy), 64'd1);
        chk("t0_addr", 64'(saddress), 64'd0);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        chk("t1_addr", 64'(saddress), 64'h037F);
        chk("t1_swr", 64'(swr), 64'd0);
        @(posedge clk); #1;
        chk("t2_swr", 64'(swr), 64'd1);
        @(posedge clk); #1;
        chk("t3_swr", 64'(swr), 64'd1);
        @(posedge clk); #1;
        chk("t4_swr", 64'(swr), 64'd0);
        chk("t4_addr", 64'(saddress), 64'h037F);
        @(posedge clk); #1;
        chk("t5_addr", 64'(saddress), 64'h0388);
        chk("t5_swr", 64'(swr), 64'd0);
        wait_done(200, "job1_done");

        // Job 2: full-scale operands, product does not fit in 32 bits.
        ready_at = 1; rsp_fit = 1'b0; rsp_w = 32'hFE00_0001; rsp_l = 32'd8;
        expect_job(24'hFFFFFF, 24'hFFFFFF, 1'b1, 32'hFE00_0001, 24'd8, 1'b0, 1'b0, 1);
        pulse_start(24'hFFFFFF, 24'hFFFFFF);
        wait_done(200, "job2_done");

        // Job 3: status never ready -> 255 polls, results untouched.
        ready_at = 0; rsp_w = 32'h1234_5678; rsp_l = 32'd77;
        expect_job(24'd1, 24'd1, 1'b0, 32'hFE00_0001, 24'd8, 1'b0, 1'b1, 255);
        pulse_start(24'd1, 24'd1);
        wait_done(3000, "job3_done");

        // Job 4: reset while WR_B strobe is high.
        push_ev(1'b1, 16'h037F, 32'h0000_0123);
        push_ev(1'b1, 16'h0388, 32'h0000_0456);
        pulse_start(24'h000123, 24'h000456);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (swr && saddress == 16'h0388) found = 1'b1;
        end
        chk("abort_reach_wrb", 64'(found), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_swr", 64'(swr), 64'd0);
        chk("abort_addr", 64'(saddress), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_results", {8'h0, result_w, ones_l}, 64'd0);
        chk("abort_bus_q", 64'(bus_q.size()), 64'd0);
        repeat (3) @(posedge clk);

        // Job 5: start present on the first edge after reset release.
        ready_at = 3; rsp_fit = 1'b1; rsp_w = 32'h0000_0200; rsp_l = 32'd2;
        expect_job(24'h10, 24'h20, 1'b1, 32'h0000_0200, 24'd2, 1'b1, 1'b0, 3);
        @(negedge clk);
        reset = 1'b0;
        arg_a = 24'h10; arg_b = 24'h20; start = 1'b1;
        @(posedge clk); #1;
        chk("first_start", 64'(busy), 64'd1);
        @(negedge clk);
        start = 1'b0;
        wait_done(300, "job5_done");

        // Jobs 6 and 7: start held high throughout; second job follows FINISH.
        ready_at = 1; rsp_fit = 1'b1; rsp_w = 32'h0000_003F; rsp_l = 32'd5;
        expect_job(24'd7, 24'd9, 1'b1, 32'h0000_003F, 24'd5, 1'b1, 1'b0, 1);
        expect_job(24'd7, 24'd9, 1'b1, 32'h0000_003F, 24'd5, 1'b1, 1'b0, 1);
        @(negedge clk);
        arg_a = 24'd7; arg_b = 24'd9; start = 1'b1;
        wait_done(200, "job6_done");
        @(posedge clk); #1;
        chk("held_idle_gap", 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk("held_restart", 64'(busy), 64'd1);
        @(negedge clk);
        start = 1'b0;
        wait_done(200, "job7_done");

        repeat (5) @(negedge clk);
        chk("bus_q_empty", 64'(bus_q.size()), 64'd0);
        chk("job_q_empty", 64'(job_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpioemu_master.md
GPIOEMU_MASTER -- requirements
Module: gpioemu_master

Interface
REQ-001 Parameter STROBE_CYCLES, default 2: cycles srd/swr held high per bus access (legal 1..15).
REQ-002 Parameter POST_TRIG_WAIT, default 8: idle cycles between trigger write and first status poll.
REQ-003 Parameter POLL_LIMIT, default 255: maximum status reads before timeout.
REQ-004 clk  in  1  single clock; all state changes on posedge clk.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  request a multiply job; sampled only in IDLE.
REQ-007 arg_a  in  24  first operand, captured on accepted start.
REQ-008 arg_b  in  24  second operand, captured on accepted start.
REQ-009 busy  out  1  high from the cycle after accepted start until done.
REQ-010 done  out  1  one-cycle pulse at job end.
REQ-011 result_w  out  32  product word read from 0x0390.
REQ-012 ones_l  out  24  ones count read from 0x0398.
REQ-013 valid  out  1  status bit B[0] from last poll (1 = product fits 32 bits).
REQ-014 timeout  out  1  high with done when POLL_LIMIT exceeded; cleared on next accepted start.
REQ-015 saddress  out  16  peripheral bus address.
REQ-016 srd  out  1  read strobe, active high.
REQ-017 swr  out  1  write strobe, active high.
REQ-018 sdata_out  out  32  write data to peripheral.
REQ-019 sdata_in  in  32  read data from peripheral.

Function
REQ-020 All outputs registered; no combinational path from inputs to outputs.
REQ-021 Bus access = 1 SETUP cycle (address/data driven, strobes low) + STROBE_CYCLES STROBE cycles (one strobe high) + 1 HOLD cycle (strobes low, address/data held); default 4 cycles.
REQ-022 Read data sampled from sdata_in in HOLD cycle; srd and swr never high simultaneously.
REQ-023 Between accesses and in IDLE: saddress=0, sdata_out=0, srd=swr=0.
REQ-024 FSM states: IDLE, WR_A, WR_B, WR_TRIG, WAIT, POLL, RD_W, RD_L, FINISH.
REQ-025 IDLE: start=1 -> capture args, clear timeout, busy=1, go WR_A; start while not IDLE ignored.
REQ-026 WR_A: write 0x037F, data {8'h0,arg_a} -> WR_B.
REQ-027 WR_B: write 0x0388, data {8'h0,arg_b} -> WR_TRIG.
REQ-028 WR_TRIG: write 0x03A0, data 0 -> WAIT; poll counter cleared.
REQ-029 WAIT: POST_TRIG_WAIT idle cycles -> POLL.
REQ-030 POLL: read 0x03A0; increment poll counter; sampled bit1=1 -> latch valid=bit0, go RD_W; else counter=POLL_LIMIT -> timeout=1, go FINISH; else repeat POLL back-to-back.
REQ-031 RD_W: read 0x0390 -> result_w; RD_L: read 0x0398, ones_l=bits[23:0] -> FINISH.
REQ-032 FINISH: done=1 for exactly one cycle, busy=0 same cycle, -> IDLE; start sampled again from next cycle.
REQ-033 On timeout result_w and ones_l keep previous values.
REQ-034 Poll counter 8 bits minimum, saturating; no wrap.

Reset
REQ-035 reset=1 asynchronously forces IDLE, all outputs 0, strobes low immediately (including mid-strobe); job aborted, no done pulse.
REQ-036 First start honoured on first posedge clk after reset deasserts.

Verification
REQ-037 start, arg_a=3, arg_b=5, responder model -> writes 0x037F/3, 0x0388/5, 0x03A0/0; done with result_w=0x0000000F, ones_l=2, valid=1, timeout=0.
REQ-038 arg_a=arg_b=0xFFFFFF, responder B=2'b10 -> valid=0, result_w=0xFFFFFE000001 lower 32 bits (0xFE000001), ones_l=8.
REQ-039 Responder never sets B[1] -> exactly 255 reads of 0x03A0, then done with timeout=1, result_w unchanged.
REQ-040 Timing check, start accepted at edge 0 -> saddress=0x037F at cycle 1, swr high cycles 2-3, low cycle 4, next address at cycle 5.
REQ-041 reset asserted during swr high of WR_B -> swr, saddress, busy 0 immediately; no done; new start after release runs full sequence.
REQ-042 start held high through a job and after done -> second job begins one cycle after FINISH; start pulses while busy ignored.
